// File: rtl/conv2_layer_sequencer.sv
// Frame-level controller for the second convolution layer: loads CI input-fmap
// banks from the layer-1 stream, launches the conv pass, counts CO completions.
module conv2_layer_sequencer #(
    parameter int CI    = 4,
    parameter int CO    = 12,
    parameter int DEPTH = 144,
    parameter int AW    = 8,
    localparam int BW   = (CI > 1) ? $clog2(CI) : 1,
    localparam int CW   = (CO > 1) ? $clog2(CO) : 1
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_l1_valid,
    input  logic          i_l1_ch_end,
    input  logic          i_conv_ch_end,
    output logic          o_l1_ready,
    output logic [CI-1:0] o_bank_we,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_rd_start,
    output logic [CW-1:0] o_co_idx,
    output logic          o_process_end,
    output logic          o_busy,
    output logic          o_err
);

    typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, RUN, DONE} state_t;

    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0] LAST_BANK = BW'(CI - 1);
    localparam logic [CW-1:0] LAST_CO   = CW'(CO - 1);

    state_t        state;
    logic [BW-1:0] bank_cnt;
    // One extra bit so the counter can sit at DEPTH even when DEPTH == 2^AW.
    logic [AW:0]   pix_cnt;
    logic          pix_full;
    logic          accept;
    logic [AW:0]   pix_with;
    logic [CI-1:0] bank_sel;

    always_comb begin
        pix_full = (pix_cnt == DEPTH_C);
        accept   = i_l1_valid & o_l1_ready & ~pix_full;
        pix_with = pix_cnt + {{AW{1'b0}}, accept};
        bank_sel = '0;
        bank_sel[bank_cnt] = 1'b1;
    end

    assign o_bank_we = accept ? bank_sel : '0;
    assign o_wr_addr = pix_cnt[AW-1:0];

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state         <= IDLE;
            bank_cnt      <= '0;
            pix_cnt       <= '0;
            o_l1_ready    <= 1'b0;
            o_rd_start    <= 1'b0;
            o_co_idx      <= '0;
            o_process_end <= 1'b0;
            o_busy        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_rd_start    <= 1'b0;
            o_process_end <= 1'b0;
            if (i_abort && state != IDLE) begin
                // Flush the datapath with a process-end pulse, never a read launch.
                state         <= IDLE;
                bank_cnt      <= '0;
                pix_cnt       <= '0;
                o_co_idx      <= '0;
                o_l1_ready    <= 1'b0;
                o_busy        <= 1'b0;
                o_process_end <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        bank_cnt <= '0;
                        pix_cnt  <= '0;
                        o_co_idx <= '0;
                        if (i_l1_valid) o_err <= 1'b1;
                        if (i_start) begin
                            state      <= LOAD;
                            o_l1_ready <= 1'b1;
                            o_busy     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (i_l1_valid && pix_full) o_err <= 1'b1;
                        if (i_l1_ch_end) begin
                            // A same-cycle pixel counts toward the channel length check.
                            if (pix_with != DEPTH_C) o_err <= 1'b1;
                            pix_cnt <= '0;
                            if (bank_cnt == LAST_BANK) begin
                                bank_cnt   <= '0;
                                state      <= LAUNCH;
                                o_l1_ready <= 1'b0;
                                o_rd_start <= 1'b1;
                            end else begin
                                bank_cnt <= bank_cnt + 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_with;
                        end
                    end
                    LAUNCH: begin
                        state <= RUN;
                    end
                    RUN: begin
                        if (i_l1_valid || i_l1_ch_end) o_err <= 1'b1;
                        if (i_conv_ch_end) begin
                            if (o_co_idx == LAST_CO) begin
                                o_co_idx      <= '0;
                                state         <= DONE;
                                o_process_end <= 1'b1;
                            end else begin
                                o_co_idx <= o_co_idx + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv2_layer_sequencer.sv
// Directed self-checking bench for conv2_layer_sequencer with default parameters.
module tb_conv2_layer_sequencer;

    localparam int CI    = 4;
    localparam int CO    = 12;
    localparam int DEPTH = 144;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          global_rst_n;
    logic          i_start, i_abort, i_l1_valid, i_l1_ch_end, i_conv_ch_end;
    logic          o_l1_ready, o_rd_start, o_process_end, o_busy, o_err;
    logic [CI-1:0] o_bank_we;
    logic [AW-1:0] o_wr_addr;
    logic [3:0]    o_co_idx;

    int check_count = 0;
    int error_count = 0;

    conv2_layer_sequencer #(.CI(CI), .CO(CO), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .global_rst_n  (global_rst_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_l1_valid    (i_l1_valid),
        .i_l1_ch_end   (i_l1_ch_end),
        .i_conv_ch_end (i_conv_ch_end),
        .o_l1_ready    (o_l1_ready),
        .o_bank_we     (o_bank_we),
        .o_wr_addr     (o_wr_addr),
        .o_rd_start    (o_rd_start),
        .o_co_idx      (o_co_idx),
        .o_process_end (o_process_end),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic ch_end, input logic conv_end,
                                 input logic start, input logic abort);
        i_l1_valid    = valid;
        i_l1_ch_end   = ch_end;
        i_conv_ch_end = conv_end;
        i_start       = start;
        i_abort       = abort;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_ready"}, o_l1_ready, 0);
        checkOutput({tag, "_we"}, o_bank_we, 0);
        checkOutput({tag, "_addr"}, o_wr_addr, 0);
        checkOutput({tag, "_rd"}, o_rd_start, 0);
        checkOutput({tag, "_co"}, o_co_idx, 0);
        checkOutput({tag, "_pend"}, o_process_end, 0);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_err"}, o_err, 0);
    endtask

    task automatic reset_dut();
        applyStimulus(0, 0, 0, 0, 0);
        global_rst_n = 1'b0;
        #3;
        check_all_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        global_rst_n = 1'b1;
        tick();
    endtask

    task automatic start_frame();
        applyStimulus(0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("start_busy", o_busy, 1);
        checkOutput("start_ready", o_l1_ready, 1);
        checkOutput("start_addr", o_wr_addr, 0);
    endtask

    // Sends npix pixels to bank ch; optionally ends the channel, either on the last pixel or after it.
    task automatic load_channel(input int ch, input int npix, input bit coinc, input bit send_end);
        logic [3:0] exp_we;
        for (int i = 0; i < npix; i++) begin
            exp_we = (i < DEPTH) ? 4'(1 << ch) : 4'b0;
            applyStimulus(1, coinc && send_end && (i == npix - 1), 0, 0, 0);
            checkOutput("bank_we", o_bank_we, exp_we);
            checkOutput("wr_addr", o_wr_addr, (i < DEPTH) ? i : DEPTH);
            checkOutput("rd_idle", o_rd_start, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0);
        if (send_end && !coinc) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("ch_end_we", o_bank_we, 0);
            tick();
            applyStimulus(0, 0, 0, 0, 0);
        end
    endtask

    task automatic launch_check();
        checkOutput("launch_rd", o_rd_start, 1);
        checkOutput("launch_ready", o_l1_ready, 0);
        checkOutput("launch_busy", o_busy, 1);
        tick();
        checkOutput("rd_pulse_end", o_rd_start, 0);
    endtask

    task automatic conv_pulses(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            checkOutput("co_idx", o_co_idx, k);
            applyStimulus(0, 0, 1, 0, 0);
            tick();
            applyStimulus(0, 0, 0, 0, 0);
            if (k != CO - 1) checkOutput("no_pend", o_process_end, 0);
        end
    endtask

    task automatic finish_check();
        checkOutput("done_pend", o_process_end, 1);
        checkOutput("done_co", o_co_idx, 0);
        checkOutput("done_busy", o_busy, 1);
        tick();
        checkOutput("pend_pulse_end", o_process_end, 0);
        checkOutput("idle_busy", o_busy, 0);
    endtask

    task automatic full_frame();
        start_frame();
        for (int ch = 0; ch < CI; ch++) load_channel(ch, DEPTH, 0, 1);
        launch_check();
        conv_pulses(0, CO);
        finish_check();
        checkOutput("frame_err", o_err, 0);
    endtask

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        reset_dut();
        check_all_zero("post_rst");

        $display("[TB] nominal frame");
        full_frame();

        $display("[TB] short channel");
        start_frame();
        load_channel(0, DEPTH, 0, 1);
        load_channel(1, 100, 0, 1);
        checkOutput("short_err", o_err, 1);
        load_channel(2, DEPTH, 0, 1);
        load_channel(3, DEPTH, 0, 1);
        launch_check();
        conv_pulses(0, CO);
        finish_check();
        checkOutput("short_err_sticky", o_err, 1);
        reset_dut();

        $display("[TB] overflow");
        start_frame();
        load_channel(0, DEPTH + 1, 0, 0);
        checkOutput("ovf_err", o_err, 1);
        checkOutput("ovf_addr_hold", o_wr_addr, DEPTH);
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("ovf_abort_pend", o_process_end, 1);
        checkOutput("ovf_abort_busy", o_busy, 0);
        tick();
        reset_dut();

        $display("[TB] coincident edge and abort mid-run");
        start_frame();
        for (int ch = 0; ch < CI; ch++) load_channel(ch, DEPTH, 1, 1);
        checkOutput("coinc_err", o_err, 0);
        launch_check();
        conv_pulses(0, 5);
        checkOutput("abort_co5", o_co_idx, 5);
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("abort_pend", o_process_end, 1);
        checkOutput("abort_co", o_co_idx, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_rd", o_rd_start, 0);
        tick();
        checkOutput("abort_pend_end", o_process_end, 0);
        full_frame();

        $display("[TB] async reset mid-load");
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("idle_valid_err", o_err, 1);
        start_frame();
        load_channel(0, DEPTH, 0, 1);
        load_channel(1, DEPTH, 0, 1);
        load_channel(2, 70, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("pre_rst_we", o_bank_we, 4'b0100);
        checkOutput("pre_rst_addr", o_wr_addr, 70);
        #2;
        global_rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        global_rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
